// File: rtl/mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates one single-ported unified instruction/data memory
//            between the fetch stage (IF) and the memory stage (DM). Each
//            access is a fixed-latency transaction. A global stall is raised
//            while either requester is waiting.
// Revision : 1.0 - initial release
//
// Optional feature (macro MEM_ARB_PERF_CNT_EN):
//   When defined, adds saturating 32-bit wait-cycle counters perf_if_wait_o
//   and perf_dm_wait_o. When undefined, those ports and counters do not exist.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   if_req_i     : fetch read request, held until if_valid_o
//   if_addr_i    : fetch address
//   if_rdata_o   : fetched instruction (held until the next IF completion)
//   if_valid_o   : one-cycle IF completion pulse
//   dm_req_i     : data request, held until dm_valid_o
//   dm_we_i      : 1 = write, 0 = read
//   dm_addr_i    : data address
//   dm_wdata_i   : write data
//   dm_be_i      : byte enables
//   dm_rdata_o   : load data (held until the next DM read completion)
//   dm_valid_o   : one-cycle DM completion pulse (reads and writes)
//   mem_en_o     : memory access strobe (one cycle per transaction)
//   mem_we_o     : memory write enable
//   mem_addr_o   : memory address
//   mem_wdata_o  : memory write data
//   mem_be_o     : memory byte enables
//   mem_rdata_i  : memory read data, valid MEM_LATENCY cycles after mem_en_o
//   stall_o      : pipeline stall
//   perf_if_wait_o / perf_dm_wait_o : wait-cycle counters (optional)
//==============================================================================
module mem_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   output logic                  if_valid_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wdata_i,
   input  logic [3:0]            dm_be_i,
   output logic [DATA_WIDTH-1:0] dm_rdata_o,
   output logic                  dm_valid_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]            mem_be_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]           perf_if_wait_o,
   output logic [31:0]           perf_dm_wait_o,
`endif
   output logic                  stall_o
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_e;

   state_e                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [STV_W-1:0]      starve_q;
   logic                  dm_wr_q;
   logic                  if_valid_q;
   logic                  dm_valid_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] dm_rdata_q;

   logic if_elig_d;
   logic dm_elig_d;
   logic starve_hit_d;
   logic grant_if_d;
   logic grant_dm_d;

   // A port is masked in its own ack cycle: its req is still high there
   // but belongs to the transaction that is just completing.
   assign if_elig_d    = if_req_i & ~if_valid_q;
   assign dm_elig_d    = dm_req_i & ~dm_valid_q;
   assign starve_hit_d = (starve_q == STV_W'(STARVE_LIMIT));

   // DM has priority except when IF has been passed over STARVE_LIMIT times.
   assign grant_dm_d = (state_q == IDLE) & dm_elig_d & ~(starve_hit_d & if_elig_d);
   assign grant_if_d = (state_q == IDLE) & if_elig_d & ~grant_dm_d;

   // Memory command is driven combinationally in the grant cycle only.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = 4'h0;
      if (grant_dm_d) begin
         mem_en_o    = 1'b1;
         mem_we_o    = dm_we_i;
         mem_addr_o  = dm_addr_i;
         mem_wdata_o = dm_wdata_i;
         mem_be_o    = dm_be_i;
      end else if (grant_if_d) begin
         mem_en_o    = 1'b1;
         mem_addr_o  = if_addr_i;
         mem_be_o    = 4'hF;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         dm_wr_q    <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_dm_d) begin
                  state_q <= BUSY_DM;
                  cnt_q   <= CNT_W'(MEM_LATENCY);
                  dm_wr_q <= dm_we_i;
                  // Bounded: with starve_q at the limit and IF eligible,
                  // IF wins, so this increment never exceeds the limit.
                  starve_q <= if_elig_d ? (starve_q + STV_W'(1)) : '0;
               end else if (grant_if_d) begin
                  state_q  <= BUSY_IF;
                  cnt_q    <= CNT_W'(MEM_LATENCY);
                  starve_q <= '0;
               end
            end
            BUSY_IF: begin
               cnt_q <= cnt_q - CNT_W'(1);
               // cnt_q == 1 marks cycle T+MEM_LATENCY, when mem_rdata is valid.
               if (cnt_q == CNT_W'(1)) begin
                  if_rdata_q <= mem_rdata_i;
                  if_valid_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            BUSY_DM: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  if (!dm_wr_q) begin
                     dm_rdata_q <= mem_rdata_i;
                  end
                  dm_valid_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign if_valid_o = if_valid_q;
   assign dm_valid_o = dm_valid_q;
   assign if_rdata_o = if_rdata_q;
   assign dm_rdata_o = dm_rdata_q;
   assign stall_o    = (if_req_i & ~if_valid_q) | (dm_req_i & ~dm_valid_q);

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_if_q;
   logic [31:0] perf_dm_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_if_q <= '0;
         perf_dm_q <= '0;
      end else begin
         if (if_req_i && !if_valid_q && !(&perf_if_q)) begin
            perf_if_q <= perf_if_q + 32'd1;
         end
         if (dm_req_i && !dm_valid_q && !(&perf_dm_q)) begin
            perf_dm_q <= perf_dm_q + 32'd1;
         end
      end
   end

   assign perf_if_wait_o = perf_if_q;
   assign perf_dm_wait_o = perf_dm_q;
`endif

endmodule
`default_nettype wire
